// File: rtl/frame_buffer_arbiter_pkg.sv
// frame_buffer_arbiter_pkg: shared client ordinals, size defaults and read-tag type.
package frame_buffer_arbiter_pkg;
    typedef enum logic [2:0] {NTSC, VGA, LPF, PTF} client_e;
    typedef enum logic {RUN, DRAIN} state_e;
    localparam int CID_W = 3;
    localparam int DEF_BUF_W = 2;
    localparam int DEF_IMAGE_WORDS = 76800;
    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 36;
    typedef struct packed {
        logic             valid;
        logic [CID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/frame_buffer_bank_port.sv
// frame_buffer_bank_port: one SRAM bank's arbiter, address mux and read-tag pipeline.
// RR_ARB_EN selects round-robin arbitration; otherwise lowest index wins.
module frame_buffer_bank_port import frame_buffer_arbiter_pkg::*; #(
    parameter int NUM_CLIENTS  = 4,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int READ_LATENCY = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CLIENTS-1:0]        eligible,
    input  logic [NUM_CLIENTS-1:0]        wr,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] addr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]        grant,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic                          mem_we,
    output tag_t                          tag_out,
    output logic                          busy
);
    logic             found;
    logic [CID_W-1:0] sel;
    logic             wr_sel;
    tag_t             pipe [READ_LATENCY];

`ifdef RR_ARB_EN
    logic [CID_W-1:0] last, low, up;
    logic             up_found;
    // Prefer the lowest eligible index above the last winner, else wrap to the lowest.
    always_comb begin
        found = 1'b0;
        low = '0;
        up_found = 1'b0;
        up = '0;
        for (int i = NUM_CLIENTS-1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                low = CID_W'(i);
            end
            if (eligible[i] && CID_W'(i) > last) begin
                up_found = 1'b1;
                up = CID_W'(i);
            end
        end
        sel = up_found ? up : low;
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) last <= CID_W'(NUM_CLIENTS-1);
        else if (found) last <= sel;
`else
    always_comb begin
        found = 1'b0;
        sel = '0;
        for (int i = NUM_CLIENTS-1; i >= 0; i--)
            if (eligible[i]) begin
                found = 1'b1;
                sel = CID_W'(i);
            end
    end
`endif

    always_comb begin
        grant = '0;
        mem_addr = '0;
        mem_wdata = '0;
        mem_we = 1'b0;
        wr_sel = 1'b0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            grant[i] = found && sel == CID_W'(i);
            if (grant[i]) begin
                mem_addr = addr[i*ADDR_W +: ADDR_W];
                mem_wdata = wdata[i*DATA_W +: DATA_W];
                mem_we = wr[i];
                wr_sel = wr[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: found && !wr_sel, id: sel};
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) busy = busy | pipe[i].valid;
    end

    assign tag_out = pipe[READ_LATENCY-1];
endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: maps NUM_CLIENTS rotating frame buffers onto two ZBT banks.
// RR_ARB_EN (in frame_buffer_bank_port) switches both banks to round-robin arbitration.
module frame_buffer_arbiter import frame_buffer_arbiter_pkg::*; #(
    parameter int NUM_CLIENTS  = 4,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int OFF_W        = 17,
    parameter int IMAGE_WORDS  = DEF_IMAGE_WORDS,
    parameter int READ_LATENCY = 2,
    localparam int BUF_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_flag,
    output logic                          frame_pending,
    input  logic [NUM_CLIENTS-1:0]        req,
    input  logic [NUM_CLIENTS-1:0]        wr,
    input  logic [NUM_CLIENTS*OFF_W-1:0]  offset,
    input  logic [NUM_CLIENTS*DATA_W-1:0] wdata,
    output logic [NUM_CLIENTS-1:0]        grant,
    output logic [NUM_CLIENTS-1:0]        rvalid,
    output logic [NUM_CLIENTS*DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]             mem0_addr,
    output logic [ADDR_W-1:0]             mem1_addr,
    output logic [DATA_W-1:0]             mem0_wdata,
    output logic [DATA_W-1:0]             mem1_wdata,
    output logic                          mem0_we,
    output logic                          mem1_we,
    input  logic [DATA_W-1:0]             mem0_rdata,
    input  logic [DATA_W-1:0]             mem1_rdata,
    output logic [NUM_CLIENTS*BUF_W-1:0]  buf_map,
    output logic                          range_err
);
    state_e                        state, state_d;
    logic [BUF_W-1:0]              map [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0]        in_range, elig0, elig1, g0, g1, hit0, hit1;
    logic [NUM_CLIENTS*ADDR_W-1:0] caddr;
    logic                          run, busy0, busy1, rotate;
    tag_t                          t0, t1;

    // Gating with reset keeps grants and bank outputs quiet while reset is held.
    assign run = state == RUN && reset;
    assign rotate = state == DRAIN && !busy0 && !busy1;
    assign frame_pending = state == DRAIN;
    assign grant = g0 | g1;

    always_comb begin
        state_d = state == RUN ? (frame_flag ? DRAIN : RUN) : (rotate ? RUN : DRAIN);
    end

    always_comb begin
        caddr = '0;
        in_range = '0;
        elig0 = '0;
        elig1 = '0;
        buf_map = '0;
        hit0 = '0;
        hit1 = '0;
        for (int c = 0; c < NUM_CLIENTS; c++) begin
            in_range[c] = 32'(offset[c*OFF_W +: OFF_W]) < 32'(IMAGE_WORDS);
            caddr[c*ADDR_W +: ADDR_W] = ADDR_W'(32'(map[c] >> 1) * 32'(IMAGE_WORDS))
                                      + ADDR_W'(offset[c*OFF_W +: OFF_W]);
            elig0[c] = run && req[c] && in_range[c] && !map[c][0];
            elig1[c] = run && req[c] && in_range[c] && map[c][0];
            buf_map[c*BUF_W +: BUF_W] = map[c];
            hit0[c] = t0.valid && t0.id == CID_W'(c);
            hit1[c] = t1.valid && t1.id == CID_W'(c);
        end
    end

    frame_buffer_bank_port #(
        .NUM_CLIENTS(NUM_CLIENTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)
    ) u_bank0 (
        .clock(clock), .reset(reset), .eligible(elig0), .wr(wr), .addr(caddr), .wdata(wdata),
        .grant(g0), .mem_addr(mem0_addr), .mem_wdata(mem0_wdata), .mem_we(mem0_we),
        .tag_out(t0), .busy(busy0)
    );

    frame_buffer_bank_port #(
        .NUM_CLIENTS(NUM_CLIENTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)
    ) u_bank1 (
        .clock(clock), .reset(reset), .eligible(elig1), .wr(wr), .addr(caddr), .wdata(wdata),
        .grant(g1), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_we(mem1_we),
        .tag_out(t1), .busy(busy1)
    );

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= RUN;
            for (int c = 0; c < NUM_CLIENTS; c++) map[c] <= BUF_W'(c);
        end else begin
            state <= state_d;
            if (rotate)
                for (int c = 0; c < NUM_CLIENTS; c++) map[c] <= map[(c+1) % NUM_CLIENTS];
        end

    always_ff @(posedge clock or negedge reset)
        if (!reset) range_err <= 1'b0;
        else if (|(req & ~in_range)) range_err <= 1'b1;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rvalid <= '0;
            rdata <= '0;
        end else begin
            rvalid <= hit0 | hit1;
            for (int c = 0; c < NUM_CLIENTS; c++) begin
                if (hit0[c]) rdata[c*DATA_W +: DATA_W] <= mem0_rdata;
                if (hit1[c]) rdata[c*DATA_W +: DATA_W] <= mem1_rdata;
            end
        end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed scoreboard bench for frame_buffer_arbiter.
module tb_frame_buffer_arbiter;
    localparam int NC = 4;
    localparam int AW = 19;
    localparam int DW = 36;
    localparam int OW = 17;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } sb_t;

    logic            clock, reset, frame_flag, frame_pending, range_err;
    logic [NC-1:0]   req, wr, grant, rvalid;
    logic [NC*OW-1:0] offset;
    logic [NC*DW-1:0] wdata, rdata;
    logic [AW-1:0]   mem0_addr, mem1_addr;
    logic [DW-1:0]   mem0_wdata, mem1_wdata, mem0_rdata, mem1_rdata;
    logic            mem0_we, mem1_we;
    logic [NC*2-1:0] buf_map;
    logic [AW-1:0]   a0_1 = '0, a0_2 = '0, a1_1 = '0, a1_2 = '0;
    int              cyc = 0, checks = 0, errors = 0;
    int              exp_w [4];
    sb_t             sbq [NC][$];
    sb_t             mon_it;

    frame_buffer_arbiter dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag), .frame_pending(frame_pending),
        .req(req), .wr(wr), .offset(offset), .wdata(wdata), .grant(grant), .rvalid(rvalid),
        .rdata(rdata), .mem0_addr(mem0_addr), .mem1_addr(mem1_addr), .mem0_wdata(mem0_wdata),
        .mem1_wdata(mem1_wdata), .mem0_we(mem0_we), .mem1_we(mem1_we), .mem0_rdata(mem0_rdata),
        .mem1_rdata(mem1_rdata), .buf_map(buf_map), .range_err(range_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: data is a fixed function of the address presented two cycles earlier.
    function automatic logic [DW-1:0] f0(input logic [AW-1:0] a);
        return {17'h1A5A5, a};
    endfunction
    function automatic logic [DW-1:0] f1(input logic [AW-1:0] a);
        return {17'h0C3C3, a};
    endfunction
    always @(posedge clock) begin
        a0_1 <= mem0_addr;
        a0_2 <= a0_1;
        a1_1 <= mem1_addr;
        a1_2 <= a1_1;
    end
    assign mem0_rdata = f0(a0_2);
    assign mem1_rdata = f1(a1_2);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        @(posedge clock);
        #1;
    endtask

    task automatic set_off(input int c, input int v);
        offset[c*OW +: OW] = OW'(v);
    endtask

    task automatic push(input int c, input logic [DW-1:0] d);
        sb_t it;
        it.due = cyc + 3;
        it.data = d;
        sbq[c].push_back(it);
    endtask

    always @(negedge clock)
        for (int c = 0; c < NC; c++)
            if (rvalid[c] === 1'b1) begin
                if (sbq[c].size() == 0) chk("rv_unexpected", rvalid[c], 1'b0);
                else begin
                    mon_it = sbq[c].pop_front();
                    chk("rd_data", rdata[c*DW +: DW], mon_it.data);
                    chk("rd_cycle", cyc, mon_it.due);
                end
            end

    initial begin
`ifdef RR_ARB_EN
        exp_w = '{0, 2, 0, 2};
`else
        exp_w = '{0, 0, 0, 0};
`endif
        reset = 1'b0;
        frame_flag = 1'b0;
        req = '1;
        wr = '1;
        offset = '0;
        set_off(0, 3);
        set_off(1, 9);
        set_off(2, 5);
        set_off(3, 0);
        wdata = {36'hD3, 36'hC2, 36'hB1, 36'hA0};
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_buf_map", buf_map, 8'hE4);
        chk("rst_rdata", 64'(rdata === '0), 1);
        chk("rst_rvalid", rvalid, 4'b0000);
        chk("rst_mem0_addr", mem0_addr, 0);
        chk("rst_mem0_we", mem0_we, 0);
        chk("rst_pending", frame_pending, 0);
        chk("rst_range_err", range_err, 0);

        start();
        reset = 1'b1;
        @(negedge clock);
        chk("rel_grant", grant, 4'b0011);
        chk("rel_mem0_addr", mem0_addr, 3);
        chk("rel_mem0_we", mem0_we, 1);
        chk("rel_mem0_wdata", mem0_wdata, 36'hA0);
        chk("rel_mem1_addr", mem1_addr, 9);

        start();
        req = 4'b0100;
        wr = '0;
        @(negedge clock);
        chk("lat_grant", grant, 4'b0100);
        chk("lat_mem0_addr", mem0_addr, 76805);
        chk("lat_mem0_we", mem0_we, 0);
        push(2, f0(19'd76805));
        start();
        req = '0;
        repeat (4) start();

        for (int k = 0; k < 4; k++) begin
            req = 4'b0101;
            @(negedge clock);
            chk("cont_grant", grant, 4'b0001 << exp_w[k]);
            chk("cont_mem0_addr", mem0_addr, exp_w[k] == 0 ? 3 : 76805);
            chk("cont_mem1_idle", {mem1_we, mem1_addr}, 0);
            push(exp_w[k], f0(exp_w[k] == 0 ? 19'd3 : 19'd76805));
            start();
        end
        req = '0;
        repeat (5) start();

        req = 4'b0010;
        @(negedge clock);
        chk("drn_grant", grant, 4'b0010);
        chk("drn_mem1_addr", mem1_addr, 9);
        push(1, f1(19'd9));
        start();
        req = '0;
        frame_flag = 1'b1;
        @(negedge clock);
        chk("drn_pend_t1", frame_pending, 0);
        start();
        frame_flag = 1'b0;
        req = '1;
        @(negedge clock);
        chk("drn_grant_t2", grant, 4'b0000);
        chk("drn_pend_t2", frame_pending, 1);
        start();
        frame_flag = 1'b1;
        @(negedge clock);
        chk("drn_grant_t3", grant, 4'b0000);
        chk("drn_pend_t3", frame_pending, 1);
        chk("drn_map_t3", buf_map, 8'hE4);
        start();
        frame_flag = 1'b0;
        req = 4'b0001;
        wr = '1;
        @(negedge clock);
        chk("drn_pend_t4", frame_pending, 0);
        chk("drn_map_t4", buf_map, 8'h39);
        chk("drn_grant_t4", grant, 4'b0001);
        chk("drn_mem1_addr_t4", mem1_addr, 3);
        chk("drn_mem1_we_t4", mem1_we, 1);
        start();
        req = '0;
        @(negedge clock);
        chk("drn_pend_t5", frame_pending, 0);
        chk("drn_map_t5", buf_map, 8'h39);

        start();
        set_off(0, 76800);
        req = 4'b0001;
        @(negedge clock);
        chk("rng_grant", grant, 4'b0000);
        chk("rng_mem1_idle", {mem1_we, mem1_addr}, 0);
        start();
        req = '0;
        @(negedge clock);
        chk("rng_err_set", range_err, 1);
        start();
        @(negedge clock);
        chk("rng_err_sticky", range_err, 1);
        start();
        set_off(0, 76799);
        req = 4'b0001;
        @(negedge clock);
        chk("rng_ok_grant", grant, 4'b0001);
        chk("rng_ok_addr", mem1_addr, 76799);
        chk("rng_err_hold", range_err, 1);

        start();
        set_off(0, 3);
        req = 4'b0011;
        wr = '0;
        @(negedge clock);
        chk("ar_grant", grant, 4'b0011);
        start();
        req = '0;
        #2 reset = 1'b0;
        @(negedge clock);
        chk("ar_rvalid", rvalid, 0);
        chk("ar_buf_map", buf_map, 8'hE4);
        chk("ar_range_err", range_err, 0);
        chk("ar_pending", frame_pending, 0);
        start();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("ar_no_rvalid", rvalid, 0);
            start();
        end
        frame_flag = 1'b1;
        @(negedge clock);
        chk("ar_rot_pend0", frame_pending, 0);
        start();
        frame_flag = 1'b0;
        @(negedge clock);
        chk("ar_rot_pend1", frame_pending, 1);
        start();
        @(negedge clock);
        chk("ar_rot_pend2", frame_pending, 0);
        chk("ar_rot_map", buf_map, 8'h39);

        repeat (4) start();
        for (int c = 0; c < NC; c++) chk("sb_empty", sbq[c].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
